// File: rtl/relm_ps2_ctrl_pkg.sv
// Shared definitions for the ReLM PS/2 host controller: FSM states, pop word layout, parity.
package relm_ps2_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StTxInh,
    StTxReq,
    StTxBits,
    StTxAck,
    StTxEnd
  } state_e;

  localparam int unsigned PopTxBusy   = 15;
  localparam int unsigned PopOvf      = 14;
  localparam int unsigned PopFrameErr = 13;
  localparam int unsigned PopTimeout  = 12;
  localparam int unsigned PopValid    = 8;

  // Bit that makes the total number of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/relm_ps2_ctrl_if.sv
// CPU-side push/pop port of the PS/2 controller on the ReLM bus.
interface relm_ps2_ctrl_if #(
  parameter int unsigned WD = 32
);
  logic [WD:0] push_d;
  logic        push_retry;
  logic [WD:0] pop_d;
  logic [WD:0] pop_q;

  modport master (output push_d, output pop_d, input push_retry, input pop_q);
  modport slave  (input push_d, input pop_d, output push_retry, output pop_q);
endinterface

// File: rtl/relm_ps2_filter.sv
// Glitch filter for one PS/2 line: level follows the pin only once FILT samples agree.
module relm_ps2_filter #(
  parameter int unsigned FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);
  logic [FILT-1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
      level  <= 1'b1;
      fall   <= 1'b0;
    end else begin
      hist_q <= {hist_q[FILT-2:0], raw};
      fall   <= 1'b0;
      if (&hist_q) begin
        level <= 1'b1;
      end else if (~|hist_q) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end
endmodule

// File: rtl/relm_ps2_ctrl.sv
// PS/2 host controller: sends command bytes to the device and queues received bytes for the CPU.
module relm_ps2_ctrl
  import relm_ps2_ctrl_pkg::*;
#(
  parameter int unsigned WD      = 32,
  parameter int unsigned FILT    = 8,
  parameter int unsigned WAF     = 4,
  parameter int unsigned INHIBIT = 5000,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic           clk,
  input  logic           rst,
  relm_ps2_ctrl_if.slave bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe
);
  localparam int unsigned CntMax = (TIMEOUT > INHIBIT) ? TIMEOUT : INHIBIT;
  localparam int unsigned CW = $clog2(CntMax + 1);
  localparam logic [CW-1:0] InhLoad = CW'(INHIBIT - 1);
  localparam logic [CW-1:0] TmoLoad = CW'(TIMEOUT - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      bit_q;
  logic [8:0]      rx_sr_q, tx_sr_q;
  logic [7:0]      mem [2**WAF];
  logic [WAF:0]    wr_ptr_q, rd_ptr_q;
  logic            ovf_q, frame_err_q, timeout_q;
  logic            f_clk, f_dat, clk_fall, unused_dat_fall, unused_bits;

  relm_ps2_filter #(.FILT(FILT)) u_clk_filt (
    .clk(clk), .rst(rst), .raw(ps2_clk_in), .level(f_clk), .fall(clk_fall)
  );
  relm_ps2_filter #(.FILT(FILT)) u_dat_filt (
    .clk(clk), .rst(rst), .raw(ps2_dat_in), .level(f_dat), .fall(unused_dat_fall)
  );
  assign unused_bits = ^{bus.push_d[WD-1:8], bus.pop_d[WD-2:0], unused_dat_fall};

  logic       empty, full, deq, flag_clr, push_acc, expired;
  logic       rx_last, rx_good, enq, ovf_set, ferr_set;
  logic [9:0] rx_frame;

  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q[WAF] != rd_ptr_q[WAF]) && (wr_ptr_q[WAF-1:0] == rd_ptr_q[WAF-1:0]);
  assign deq      = bus.pop_d[WD] && !empty;
  // A non-blocking read on an empty queue still acknowledges (and clears) the flags.
  assign flag_clr = bus.pop_d[WD] && (!empty || bus.pop_d[WD-1]);
  assign push_acc = bus.push_d[WD] && state_q == StIdle;
  assign expired  = (state_q inside {StRx, StTxReq, StTxBits, StTxAck, StTxEnd}) &&
                    !clk_fall && cnt_q == '0;
  assign rx_frame = {f_dat, rx_sr_q};
  assign rx_last  = state_q == StRx && clk_fall && bit_q == 4'd9;
  assign rx_good  = rx_last && rx_frame[9] && rx_frame[8] == odd_parity(rx_frame[7:0]);
  assign enq      = rx_good && (!full || deq);
  assign ovf_set  = rx_good && full && !deq;
  assign ferr_set = (rx_last && !rx_good) || (state_q == StTxAck && clk_fall && f_dat);

  assign bus.push_retry = state_q != StIdle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (push_acc) begin
            state_q    <= StTxInh;
            ps2_clk_oe <= 1'b1;
            cnt_q      <= InhLoad;
            tx_sr_q    <= {odd_parity(bus.push_d[7:0]), bus.push_d[7:0]};
          end else if (clk_fall && !f_dat) begin
            state_q <= StRx;
            bit_q   <= '0;
            cnt_q   <= TmoLoad;
          end
        end
        StTxInh: begin
          if (cnt_q == '0) begin
            state_q    <= StTxReq;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            cnt_q      <= TmoLoad;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          if (clk_fall) begin
            cnt_q <= TmoLoad;
            case (state_q)
              StRx: begin
                rx_sr_q <= {f_dat, rx_sr_q[8:1]};
                bit_q   <= bit_q + 4'd1;
                if (bit_q == 4'd9) state_q <= StIdle;
              end
              StTxReq: begin
                ps2_dat_oe <= ~tx_sr_q[0];
                tx_sr_q    <= {1'b0, tx_sr_q[8:1]};
                bit_q      <= 4'd1;
                state_q    <= StTxBits;
              end
              StTxBits: begin
                if (bit_q == 4'd9) begin
                  ps2_dat_oe <= 1'b0;
                  state_q    <= StTxAck;
                end else begin
                  ps2_dat_oe <= ~tx_sr_q[0];
                  tx_sr_q    <= {1'b0, tx_sr_q[8:1]};
                  bit_q      <= bit_q + 4'd1;
                end
              end
              StTxAck: state_q <= StTxEnd;
              default: ;
            endcase
          end else if (expired) begin
            state_q    <= StIdle;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            if (state_q == StTxEnd && f_clk && f_dat) state_q <= StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + (WAF + 1)'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + (WAF + 1)'(1);
      ovf_q       <= (ovf_q && !flag_clr) || ovf_set;
      frame_err_q <= (frame_err_q && !flag_clr) || ferr_set;
      timeout_q   <= (timeout_q && !flag_clr) || expired;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr_q[WAF-1:0]] <= rx_frame[7:0];
  end

  logic [WD:0] pop;
  always_comb begin
    pop              = '0;
    pop[WD]          = empty && !bus.pop_d[WD-1];
    pop[PopTxBusy]   = state_q inside {StTxInh, StTxReq, StTxBits, StTxAck, StTxEnd};
    pop[PopOvf]      = ovf_q;
    pop[PopFrameErr] = frame_err_q;
    pop[PopTimeout]  = timeout_q;
    pop[PopValid]    = !empty;
    if (!empty) pop[7:0] = mem[rd_ptr_q[WAF-1:0]];
  end
  assign bus.pop_q = pop;

endmodule
